// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single-beat register commands into AXI4-Lite transactions, one in flight.
// Optional watchdog with sticky timeout output is enabled by defining AXIL_CMD_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int unsigned P_AXI_ADDR_WIDTH = 13,
  parameter int unsigned P_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [P_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [P_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [P_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [P_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_we,
  output logic                            busy,
`ifdef AXIL_CMD_TIMEOUT_EN
  output logic                            timeout,
`endif
  output logic [P_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [P_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [P_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [P_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [P_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int unsigned AW     = P_AXI_ADDR_WIDTH;
  localparam int unsigned DW     = P_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = P_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_t;

  state_t              state, state_nxt;
  logic                cmd_ready_nxt, busy_nxt;
  logic                rsp_valid_nxt, rsp_we_nxt;
  logic [DW-1:0]       rsp_rdata_nxt, wdata_nxt;
  logic [1:0]          rsp_resp_nxt;
  logic [AW-1:0]       awaddr_nxt, araddr_nxt;
  logic [STRB_W-1:0]   wstrb_nxt;
  logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic                accept_c;

  assign accept_c = cmd_valid && cmd_ready;

  // State and every registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_we        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cmd_ready     <= cmd_ready_nxt;
      busy          <= busy_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_rdata     <= rsp_rdata_nxt;
      rsp_resp      <= rsp_resp_nxt;
      rsp_we        <= rsp_we_nxt;
      m_axi_awaddr  <= awaddr_nxt;
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wdata   <= wdata_nxt;
      m_axi_wstrb   <= wstrb_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      m_axi_bready  <= bready_nxt;
      m_axi_araddr  <= araddr_nxt;
      m_axi_arvalid <= arvalid_nxt;
      m_axi_rready  <= rready_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_resp_nxt  = rsp_resp;
    rsp_we_nxt    = rsp_we;
    awaddr_nxt    = m_axi_awaddr;
    awvalid_nxt   = m_axi_awvalid;
    wdata_nxt     = m_axi_wdata;
    wstrb_nxt     = m_axi_wstrb;
    wvalid_nxt    = m_axi_wvalid;
    bready_nxt    = m_axi_bready;
    araddr_nxt    = m_axi_araddr;
    arvalid_nxt   = m_axi_arvalid;
    rready_nxt    = m_axi_rready;

    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          rsp_we_nxt = cmd_we;
          if (cmd_we) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = S_WR;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently, in any order
        if (m_axi_awvalid && m_axi_awready) awvalid_nxt = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          rsp_resp_nxt  = m_axi_bresp;
          rsp_rdata_nxt = '0;
          bready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arvalid && m_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid && m_axi_rready) begin
          rsp_rdata_nxt = m_axi_rdata;
          rsp_resp_nxt  = m_axi_rresp;
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == S_IDLE);
    busy_nxt      = (state_nxt != S_IDLE);
  end

`ifdef AXIL_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(P_TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_active_c;

  assign to_active_c = (state != S_IDLE) && (state != S_RSP) && (state_nxt == state);

  // Watchdog only flags; the AXI transaction keeps waiting for its handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!to_active_c)
        to_cnt <= '0;
      else if (to_cnt != TO_W'(P_TIMEOUT_CYCLES))
        to_cnt <= to_cnt + TO_W'(1);
      if (accept_c)
        timeout <= 1'b0;
      else if (to_active_c && (to_cnt == TO_W'(P_TIMEOUT_CYCLES - 1)))
        timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master: directed latency/reset cases plus randomized traffic
// against a word-memory reference model and a behavioural AXI4-Lite slave with programmable delays.
module tb_axi_lite_cmd_master;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int LIMIT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  axi_lite_cmd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_we(rsp_we), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Slave behaviour shared by the slave and the reference model
  function automatic logic [31:0] init_word(input int i);
    return (i == 509) ? 32'h0000_0009 : (32'(i) ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [1:0] resp_rule(input logic [AW-1:0] a, input logic fe);
    return (fe || a[12]) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Slave configuration (written by the main sequence only)
  int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic force_err = 1'b0;

  // Slave state (written by the slave process only)
  logic [31:0]   s_mem [2048];
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  int            b_count = 0;

  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, awv_s, wv_s, arv_s;
    logic have_aw, have_w, have_ar;
    logic [AW-1:0] awaddr_s, araddr_s;
    logic [31:0] wdata_s;
    logic [3:0]  wstrb_s;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    for (int i = 0; i < 2048; i++) s_mem[i] = init_word(i);
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
    have_aw = 0; have_w = 0; have_ar = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      aw_hs = m_axi_awvalid && m_axi_awready;  awv_s = m_axi_awvalid;
      w_hs  = m_axi_wvalid  && m_axi_wready;   wv_s  = m_axi_wvalid;
      ar_hs = m_axi_arvalid && m_axi_arready;  arv_s = m_axi_arvalid;
      b_hs  = m_axi_bvalid  && m_axi_bready;
      r_hs  = m_axi_rvalid  && m_axi_rready;
      awaddr_s = m_axi_awaddr; araddr_s = m_axi_araddr;
      wdata_s = m_axi_wdata; wstrb_s = m_axi_wstrb;
      @(posedge clk); #1;
      if (rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        continue;
      end
      if (aw_hs) begin have_aw = 1; s_awaddr = awaddr_s; aw_wait = 0; end
      else if (awv_s) aw_wait++;
      if (w_hs) begin have_w = 1; s_wdata = wdata_s; s_wstrb = wstrb_s; w_wait = 0; end
      else if (wv_s) w_wait++;
      if (ar_hs) begin have_ar = 1; s_araddr = araddr_s; ar_wait = 0; end
      else if (arv_s) ar_wait++;
      if (b_hs) begin m_axi_bvalid = 0; b_count++; end
      if (r_hs) m_axi_rvalid = 0;
      if (have_aw && have_w && !m_axi_bvalid) begin
        if (b_wait >= b_dly) begin
          m_axi_bresp = resp_rule(s_awaddr, force_err);
          if (m_axi_bresp == 2'b00)
            s_mem[s_awaddr[12:2]] = merge(s_mem[s_awaddr[12:2]], s_wdata, s_wstrb);
          m_axi_bvalid = 1; have_aw = 0; have_w = 0; b_wait = 0;
        end else b_wait++;
      end
      if (have_ar && !m_axi_rvalid) begin
        if (r_wait >= r_dly) begin
          m_axi_rdata = s_mem[s_araddr[12:2]];
          m_axi_rresp = resp_rule(s_araddr, force_err);
          m_axi_rvalid = 1; have_ar = 0; r_wait = 0;
        end else r_wait++;
      end
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
      m_axi_wready  = m_axi_wvalid  && (w_wait  >= w_dly);
      m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
    end
  end

  // Protocol monitor: valids held until handshake with stable payload
  logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awaddr = 0, p_araddr = 0;
  logic [31:0]   p_wdata = 0;
  int            aw_cycles = 0, w_cycles = 0, ar_cycles = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (p_awv && !p_awr) begin
        check("aw_held", 32'(m_axi_awvalid), 32'd1);
        check("awaddr_stable", 32'(m_axi_awaddr), 32'(p_awaddr));
      end
      if (p_wv && !p_wr) begin
        check("w_held", 32'(m_axi_wvalid), 32'd1);
        check("wdata_stable", m_axi_wdata, p_wdata);
      end
      if (p_arv && !p_arr) begin
        check("ar_held", 32'(m_axi_arvalid), 32'd1);
        check("araddr_stable", 32'(m_axi_araddr), 32'(p_araddr));
      end
      if (m_axi_awvalid) aw_cycles++;
      if (m_axi_wvalid)  w_cycles++;
      if (m_axi_arvalid) ar_cycles++;
    end
    p_awv = !rst && m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
    p_wv  = !rst && m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata  = m_axi_wdata;
    p_arv = !rst && m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
  end

  // Reference model: word memory updated per accepted write
  logic [31:0] ref_mem [2048];

  task automatic model_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, output logic [31:0] erd, output logic [1:0] ers);
    ers = resp_rule(a, force_err);
    erd = we ? 32'd0 : ref_mem[a[12:2]];
    if (we && ers == 2'b00) ref_mem[a[12:2]] = merge(ref_mem[a[12:2]], wd, ws);
  endtask

  // Issue one command from a negedge, hold the response 'hold' cycles, then consume it
  task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold);
    logic [31:0] erd;
    logic [1:0]  ers;
    int n;
    model_cmd(we, a, wd, ws, erd, ers);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
    check("cmd_accept", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    cmd_valid = 0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_we = ~we;
    check("busy_after_accept", 32'({busy, cmd_ready}), 32'b10);
    n = 0;
    while (!rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    check("rsp_arrive", 32'(n < LIMIT), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", 32'({rsp_valid, cmd_ready}), 32'b10);
      check("hold_rdata", rsp_rdata, erd);
      @(negedge clk);
    end
    check("rsp_rdata", rsp_rdata, erd);
    check("rsp_resp", 32'(rsp_resp), 32'(ers));
    check("rsp_we", 32'(rsp_we), 32'(we));
    check("axi_addr", 32'(we ? s_awaddr : s_araddr), 32'(a));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("back_to_idle", 32'({rsp_valid, busy, cmd_ready}), 32'b001);
  endtask

  initial begin : main
    logic [31:0] erd;
    logic [1:0]  ers;
    int a0, w0, r0, b0, n;
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    #3;
    check("rst_ctrl", 32'({cmd_ready, busy, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                           m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
    check("rst_data", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("rst_release", 32'({cmd_ready, busy}), 32'b10);

    // Minimum-latency write
    model_cmd(1'b1, 13'h07FC, 32'hDEADBEEF, 4'hF, erd, ers);
    cmd_valid = 1; cmd_we = 1; cmd_addr = 13'h07FC; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    check("wr_n1_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, cmd_ready}), 32'b11010);
    check("wr_n1_awaddr", 32'(m_axi_awaddr), 32'h07FC);
    check("wr_n1_wdata", m_axi_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_n2_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid}), 32'b0010);
    @(negedge clk);
    check("wr_n3_ctrl", 32'({m_axi_bready, rsp_valid, rsp_we}), 32'b011);
    check("wr_n3_rdata", rsp_rdata, erd);
    check("wr_n3_resp", 32'(rsp_resp), 32'(ers));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("wr_idle", 32'({rsp_valid, busy, cmd_ready}), 32'b001);

    // Read with arready delayed 3 cycles
    ar_dly = 3; a0 = ar_cycles;
    do_cmd(1'b0, 13'h07F4, 32'h0, 4'h0, 0);
    check("rd_ar_cycles", 32'(ar_cycles - a0), 32'd4);
    ar_dly = 0;

    // W accepted first, AW in the fourth cycle
    aw_dly = 3; w_dly = 0; a0 = aw_cycles; w0 = w_cycles; b0 = b_count;
    do_cmd(1'b1, 13'h0123, 32'h1234_5678, 4'b0101, 0);
    check("split_aw_cycles", 32'(aw_cycles - a0), 32'd4);
    check("split_w_cycles", 32'(w_cycles - w0), 32'd1);
    check("split_b_count", 32'(b_count - b0), 32'd1);
    aw_dly = 0;

    // SLVERR passthrough with the consumer stalling 5 cycles
    force_err = 1;
    do_cmd(1'b1, 13'h0040, 32'hCAFE_F00D, 4'hF, 5);
    force_err = 0;

    // Asynchronous reset while waiting for R
    r_dly = 20;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 13'h0200;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!m_axi_rready && n < LIMIT) begin @(negedge clk); n++; end
    check("rd_reach_rdata", 32'(n < LIMIT), 32'd1);
    #2 rst = 1;
    #1;
    check("async_rst", 32'({m_axi_arvalid, m_axi_rready, rsp_valid, busy, cmd_ready}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    check("rst_ready_after", 32'({cmd_ready, busy}), 32'b10);
    r_dly = 0;

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 3);
      do_cmd(1'($urandom), AW'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite read/write transactions on its m_axi_* port.
- Drives the AXI-Lite slave port of the Ethernet MAC core (13-bit address, 32-bit data) so the MAC registers and packet buffers can be reached from a simple command/response stream.
- Exactly one transaction in flight; the response is held until the consumer accepts it.

Parameters:
- P_AXI_ADDR_WIDTH, 13, AXI address width.
- P_AXI_DATA_WIDTH, 32, AXI data width; the strobe width is P_AXI_DATA_WIDTH/8.
- P_TIMEOUT_CYCLES, 1024, watchdog limit; used only when AXIL_CMD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  Single clock for all logic.
- rst  in  1  Asynchronous, active-high reset.
- cmd_valid  in  1  Command present.
- cmd_ready  out  1  Command accepted when cmd_valid and cmd_ready are both high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  P_AXI_ADDR_WIDTH  Byte address.
- cmd_wdata  in  P_AXI_DATA_WIDTH  Write data.
- cmd_wstrb  in  P_AXI_DATA_WIDTH/8  Write strobes.
- rsp_valid  out  1  Response present.
- rsp_ready  in  1  Response consumed.
- rsp_rdata  out  P_AXI_DATA_WIDTH  Read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_we  out  1  Echo of the command's cmd_we.
- busy  out  1  High whenever the FSM is not in IDLE.
- m_axi_awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready: standard AXI4-Lite master signals. Directions are the master side; widths follow the parameters.
- timeout  out  1  Sticky watchdog flag; exists only with AXIL_CMD_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0 immediately, except cmd_ready.
  - cmd_ready is 0 while rst is high and 1 in the first cycle after release.
  - FSM goes to IDLE.
  - A transaction in flight is abandoned; the valid signals drop at once.
- All AXI and response outputs are registered; there are no combinational paths from AXI inputs to AXI outputs.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On handshake at edge N, capture addr, wdata, wstrb and we.
  - Write: go to WR; awvalid and wvalid are high from cycle N+1.
  - Read: go to RD_ADDR; arvalid is high from cycle N+1.
- WR:
  - awvalid and wvalid are tracked independently. Each drops the cycle after its own handshake (valid & ready).
  - Either order of handshake is legal, as is both in the same cycle.
  - Once both have handshaked, go to WR_RESP with bready = 1.
  - awaddr, wdata and wstrb stay stable while the corresponding valid is high.
- WR_RESP: on bvalid & bready, capture bresp, set rsp_rdata = 0, drop bready, go to RSP.
- RD_ADDR: on arvalid & arready, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata and rresp, drop rready, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_rdata, rsp_resp and rsp_we are held stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready is not asserted in the same cycle: there are no back-to-back accepts.
- No valid signal is ever deasserted before its handshake, and no valid depends on a ready.
- Minimum latency, with all slave readies high and rsp_ready high:
  - Write: cmd accept at N, AW/W at N+1, B at N+2, rsp_valid at N+3.
  - Read: cmd accept at N, AR at N+1, R at N+2, rsp_valid at N+3.
- A command presented while the block is busy waits; cmd_ready stays low.
- An error response (SLVERR/DECERR) is passed through unchanged; there is no retry.
- Addresses are passed through unaligned, with no masking.

Optional Feature:
- Macro: AXIL_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs whenever the FSM is not in IDLE or RSP.
  - When it reaches P_TIMEOUT_CYCLES, the sticky timeout output is set.
  - The transaction is not aborted; AXI valids are held, as the protocol requires.
  - timeout is cleared on the next cmd handshake or on reset.
  - The counter resets on every state change.
- Undefined: no counter, no timeout port, and identical behaviour otherwise.

Test Plan:
- Write 0x0000_07FC ← 0xDEADBEEF with wstrb 0xF, slave always ready, bresp 0 -> AW/W at N+1, bready at N+2, rsp_valid at N+3 with resp 0, rdata 0 and rsp_we 1.
- Read 0x07F4 with slave rdata 0x0000_0009 and arready delayed 3 cycles -> arvalid held 3 cycles with araddr stable, then rsp_rdata 0x9 and resp 0.
- Write with wready at cycle 1 and awready at cycle 4 -> wvalid drops after cycle 1 and awvalid holds until cycle 4; exactly one B is accepted.
- bresp 2'b10 and rsp_ready held low 5 cycles -> rsp_valid and data stable 5 cycles, cmd_ready 0 throughout; IDLE after the accept.
- rst pulsed while in RD_DATA -> arvalid, rready and rsp_valid go 0 asynchronously; cmd_ready is 1 the cycle after release.
- With AXIL_CMD_TIMEOUT_EN and P_TIMEOUT_CYCLES=16, arready never asserted -> timeout rises after 16 cycles while arvalid stays 1; timeout clears on the next accepted command.
